// File: rtl/capture_if.sv
// capture_if: control, sample-stream and RAM-write signals of the capture controller
interface capture_if #(
  parameter int WIDTH   = 9,
  parameter int D_WIDTH = 8
);
  logic               start_i;
  logic               abort_i;
  logic               trig_en_i;
  logic [D_WIDTH-1:0] trig_level_i;
  logic [WIDTH:0]     len_i;
  logic               in_valid_i;
  logic [D_WIDTH-1:0] in_data_i;
  logic               wr_en_o;
  logic [WIDTH-1:0]   wr_addr_o;
  logic [D_WIDTH-1:0] wr_data_o;
  logic [WIDTH:0]     count_o;
  logic               busy_o;
  logic               done_o;
  modport master (
    output start_i, abort_i, trig_en_i, trig_level_i, len_i, in_valid_i, in_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o, done_o
  );
  modport slave (
    input  start_i, abort_i, trig_en_i, trig_level_i, len_i, in_valid_i, in_data_i,
    output wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o, done_o
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: optionally level-triggered sample capture into a 2^WIDTH-deep RAM
module capture_ctrl #(
  parameter int WIDTH   = 9,
  parameter int D_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t             state_q;
  logic [WIDTH:0]     len_q, count_q, count_d, len_eff;
  logic [WIDTH-1:0]   addr_q, wr_addr_q;
  logic [D_WIDTH-1:0] prev_q, wr_data_q;
  logic               primed_q, wr_en_q, busy_q, done_q;
  logic               trig, accept, last;
  always_comb begin
    len_eff = (len_q == '0) ? {1'b1, {WIDTH{1'b0}}} : len_q;
    count_d = count_q + 1'b1;
    last    = count_d == len_eff;
    trig    = primed_q && prev_q < bus.trig_level_i && bus.in_data_i >= bus.trig_level_i;
    accept  = bus.in_valid_i && (state_q == CAPTURE || (state_q == ARMED && trig));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.start_i) begin
            len_q    <= bus.len_i;
            count_q  <= '0;
            addr_q   <= '0;
            primed_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= bus.trig_en_i ? ARMED : CAPTURE;
          end
          ARMED: if (bus.in_valid_i) begin
            prev_q   <= bus.in_data_i;
            primed_q <= 1'b1;
          end
          CAPTURE: ;
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
        // accepted sample (trigger or capture) overrides the state decision above
        if (accept) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= bus.in_data_i;
          addr_q    <= addr_q + 1'b1;
          count_q   <= count_d;
          done_q    <= last;
          state_q   <= last ? DONE : CAPTURE;
        end
      end
    end
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.count_o   = count_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven cycle vectors plus an async-reset sequence
module tb_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  capture_if #(.WIDTH(3), .D_WIDTH(8)) bus ();
  capture_ctrl #(.WIDTH(3), .D_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic st, ab, te; logic [7:0] lvl; logic [3:0] len; logic v; logic [7:0] d;
    logic we; logic [2:0] a; logic [7:0] wd; logic [3:0] c; logic b, dn;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic st, ab, te, logic [7:0] lvl, logic [3:0] len, logic v,
                              logic [7:0] d, logic we, logic [2:0] a, logic [7:0] wd,
                              logic [3:0] c, logic b, dn);
    vec_t r;
    r.st = st; r.ab = ab; r.te = te; r.lvl = lvl; r.len = len; r.v = v; r.d = d;
    r.we = we; r.a = a; r.wd = wd; r.c = c; r.b = b; r.dn = dn;
    tbl.push_back(r);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(string tag, logic we, logic [2:0] a, logic [7:0] wd, logic [3:0] c, logic b, dn);
    chk({tag, ".wr_en"}, 32'(bus.wr_en_o), 32'(we));
    chk({tag, ".wr_addr"}, 32'(bus.wr_addr_o), 32'(a));
    chk({tag, ".wr_data"}, 32'(bus.wr_data_o), 32'(wd));
    chk({tag, ".count"}, 32'(bus.count_o), 32'(c));
    chk({tag, ".busy"}, 32'(bus.busy_o), 32'(b));
    chk({tag, ".done"}, 32'(bus.done_o), 32'(dn));
  endtask
  task automatic drive(logic st, ab, te, logic [7:0] lvl, logic [3:0] len, logic v, logic [7:0] d);
    bus.start_i = st; bus.abort_i = ab; bus.trig_en_i = te; bus.trig_level_i = lvl;
    bus.len_i = len; bus.in_valid_i = v; bus.in_data_i = d;
  endtask
  initial begin
    //  st ab te lvl len v  d      we a  wd   c  b  dn
    // continuous capture, len 4
    add(1, 0, 0, 0,   4, 0, 0,     0, 0, 0,   0, 1, 0);
    add(0, 0, 0, 0,   4, 1, 10,    1, 0, 10,  1, 1, 0);
    add(0, 0, 0, 0,   4, 1, 11,    1, 1, 11,  2, 1, 0);
    add(0, 0, 0, 0,   4, 1, 12,    1, 2, 12,  3, 1, 0);
    add(0, 0, 0, 0,   4, 1, 13,    1, 3, 13,  4, 1, 1);
    add(0, 0, 0, 0,   4, 1, 14,    0, 3, 13,  4, 0, 0);
    // rising-crossing trigger at 100; first sample only primes
    add(1, 0, 1, 100, 2, 0, 0,     0, 3, 13,  0, 1, 0);
    add(0, 0, 1, 100, 2, 1, 120,   0, 3, 13,  0, 1, 0);
    add(0, 0, 1, 100, 2, 1, 90,    0, 3, 13,  0, 1, 0);
    add(0, 0, 1, 100, 2, 1, 99,    0, 3, 13,  0, 1, 0);
    add(0, 0, 1, 100, 2, 1, 100,   1, 0, 100, 1, 1, 0);
    add(0, 0, 1, 100, 2, 1, 101,   1, 1, 101, 2, 1, 1);
    add(0, 0, 1, 100, 2, 0, 0,     0, 1, 101, 2, 0, 0);
    // len 0 = full buffer of 8, address wraps are not exceeded
    add(1, 0, 0, 0,   0, 0, 0,     0, 1, 101, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0, 0, 1, 8'(50 + k), 1, 3'(k), 8'(50 + k), 4'(k + 1), 1, k == 7);
    add(0, 0, 0, 0,   0, 1, 58,    0, 7, 57,  8, 0, 0);
    add(0, 0, 0, 0,   0, 1, 59,    0, 7, 57,  8, 0, 0);
    // abort with the third sample
    add(1, 0, 0, 0,   5, 0, 0,     0, 7, 57,  0, 1, 0);
    add(0, 0, 0, 0,   5, 1, 1,     1, 0, 1,   1, 1, 0);
    add(0, 0, 0, 0,   5, 1, 2,     1, 1, 2,   2, 1, 0);
    add(0, 1, 0, 0,   5, 1, 3,     0, 1, 2,   2, 0, 0);
    add(0, 0, 0, 0,   5, 1, 4,     0, 1, 2,   2, 0, 0);
    // gapped valid with stray starts during capture
    add(1, 0, 0, 0,   3, 0, 0,     0, 1, 2,   0, 1, 0);
    add(0, 0, 0, 0,   3, 1, 20,    1, 0, 20,  1, 1, 0);
    add(1, 0, 0, 0,   3, 0, 99,    0, 0, 20,  1, 1, 0);
    add(0, 0, 0, 0,   3, 0, 98,    0, 0, 20,  1, 1, 0);
    add(0, 0, 0, 0,   3, 1, 21,    1, 1, 21,  2, 1, 0);
    add(1, 0, 0, 0,   3, 0, 97,    0, 1, 21,  2, 1, 0);
    add(0, 0, 0, 0,   3, 0, 96,    0, 1, 21,  2, 1, 0);
    add(0, 0, 0, 0,   3, 1, 22,    1, 2, 22,  3, 1, 1);
    add(0, 0, 0, 0,   3, 0, 0,     0, 2, 22,  3, 0, 0);
    // abort beats start in IDLE; count is not cleared
    add(1, 1, 0, 0,   3, 0, 0,     0, 2, 22,  3, 0, 0);
    add(0, 0, 0, 0,   3, 1, 5,     0, 2, 22,  3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].st, tbl[i].ab, tbl[i].te, tbl[i].lvl, tbl[i].len, tbl[i].v, tbl[i].d);
      @(posedge clk);
      #1 chk_out($sformatf("row%0d", i), tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].c, tbl[i].b, tbl[i].dn);
    end
    // asynchronous reset in the middle of a capture
    @(negedge clk) drive(1, 0, 0, 0, 6, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0, 6, 1, 30);
    @(posedge clk) #1 chk_out("pre_rst0", 1, 0, 30, 1, 1, 0);
    @(negedge clk) drive(0, 0, 0, 0, 6, 1, 31);
    @(posedge clk) #1 chk_out("pre_rst1", 1, 1, 31, 2, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk) begin rst_n = 1'b1; drive(0, 0, 0, 0, 6, 1, 32); end
    @(posedge clk) #1 chk_out("post_rst_idle", 0, 0, 0, 0, 0, 0);
    @(negedge clk) drive(1, 0, 0, 0, 6, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0, 6, 1, 40);
    @(posedge clk) #1 chk_out("restart", 1, 0, 40, 1, 1, 0);
    @(negedge clk) drive(0, 1, 0, 0, 6, 0, 0);
    @(posedge clk) #1 chk_out("final_abort", 0, 0, 40, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
